// File: rtl/operand_stepper_pkg.sv
// operand_stepper_pkg
//   Shared definitions for the operand stepper: the playback state encoding
//   and the layout of one table entry, packed as {dly, a, b} with b in the
//   least significant bits.
package operand_stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Total width of one packed {dly, a, b} table entry.
    function automatic int entry_width(input int dly_w, input int width);
        return dly_w + 2 * width;
    endfunction

endpackage

// File: rtl/operand_stepper_op_table.sv
// op_table
//   DEPTH x {dly, a, b} register file. It has one synchronous write port and
//   one combinational read port. An asynchronous active-low reset clears every
//   entry.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   wr_en/wr_addr    write strobe and entry index
//   wr_data          packed {dly, a, b} to store
//   rd_addr          entry index to read
//   rd_data          packed entry at rd_addr (combinational)
module op_table
    import operand_stepper_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int DLY_W = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int EW    = entry_width(DLY_W, WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [EW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [EW-1:0] rd_data
);

    logic [EW-1:0] rows [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [EW-1:0] entry_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (wr_en && (wr_addr == AW'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign rows[gi] = entry_reg;
        end
    endgenerate

    // The read path is combinational. A load on the same edge as a write to
    // that entry therefore sees the old contents.
    assign rd_data = rows[rd_addr];

endmodule

// File: rtl/operand_stepper.sv
// operand_stepper
//   Programmable operand source for the 4-bit adder. On start it plays table
//   entries 0..len-1 in order. Before each pair it waits the idle cycles given
//   by that entry's dly field. It then presents the pair over a valid/ready
//   handshake.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   wr_en/wr_addr/wr_a/wr_b/wr_dly   table write port (accepted in any state)
//   len                              entries to play, clamped to DEPTH
//   start, abort                     playback control
//   a_out, b_out, out_valid          operand pair to the adder
//   out_ready                        downstream accept
//   busy                             high while waiting or presenting
//   done                             one-cycle pulse at sequence end
module operand_stepper
    import operand_stepper_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int DLY_W = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_a,
    input  logic [WIDTH-1:0] wr_b,
    input  logic [DLY_W-1:0] wr_dly,
    input  logic [AW:0]      len,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int EW = entry_width(DLY_W, WIDTH);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    state_t           state_reg, state_next;
    logic [AW-1:0]    index_reg, index_next;
    logic [AW-1:0]    last_reg, last_next;
    logic [DLY_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;

    logic [AW-1:0]    rd_addr;
    logic [EW-1:0]    rd_data;
    logic [DLY_W-1:0] rd_dly;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic [AW:0]      len_clamped;

    op_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .DLY_W (DLY_W),
        .AW    (AW),
        .EW    (EW)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({wr_dly, wr_a, wr_b}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign rd_dly = rd_data[EW-1 -: DLY_W];
    assign rd_a   = rd_data[2*WIDTH-1 -: WIDTH];
    assign rd_b   = rd_data[WIDTH-1:0];

    assign len_clamped = (len > DEPTH_V) ? DEPTH_V : len;

    // A single read port serves all three lookups. In IDLE it reads entry 0
    // for its delay. In WAIT it reads the entry about to be loaded. In PRESENT
    // it reads the following entry's delay for the handshake. In PRESENT of
    // the last entry this read is out of range and its result is unused.
    always_comb begin
        rd_addr = '0;
        case (state_reg)
            ST_WAIT:    rd_addr = index_reg;
            ST_PRESENT: rd_addr = index_reg + AW'(1);
            default:    rd_addr = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            index_reg <= '0;
            last_reg  <= '0;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (len_clamped == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        last_next  = AW'(len_clamped - (AW+1)'(1));
                        index_next = '0;
                        cnt_next   = rd_dly;
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - DLY_W'(1);
                end else begin
                    a_next     = rd_a;
                    b_next     = rd_b;
                    state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (out_ready) begin
                    if (index_reg == last_reg) begin
                        state_next = ST_DONE;
                    end else begin
                        index_next = index_reg + AW'(1);
                        cnt_next   = rd_dly;
                        state_next = ST_WAIT;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign a_out     = a_reg;
    assign b_out     = b_reg;
    assign out_valid = (state_reg == ST_PRESENT);
    assign busy      = (state_reg == ST_WAIT) || (state_reg == ST_PRESENT);
    assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_operand_stepper.sv
module tb_operand_stepper;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int DLY_W = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_a = '0;
    logic [WIDTH-1:0] wr_b = '0;
    logic [DLY_W-1:0] wr_dly = '0;
    logic [AW:0]      len = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             out_valid;
    logic             busy;
    logic             done;

    int tests = 0;
    int fails = 0;

    // Reference table contents and the last pair the source presented.
    int m_dly [DEPTH];
    int m_a   [DEPTH];
    int m_b   [DEPTH];
    int last_a = 0;
    int last_b = 0;

    operand_stepper #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .DLY_W (DLY_W),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_a      (wr_a),
        .wr_b      (wr_b),
        .wr_dly    (wr_dly),
        .len       (len),
        .start     (start),
        .abort     (abort),
        .a_out     (a_out),
        .b_out     (b_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle. Outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic twrite(input int addr, input int a, input int b, input int dly);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_a    = WIDTH'(a);
        wr_b    = WIDTH'(b);
        wr_dly  = DLY_W'(dly);
        step();
        wr_en   = 1'b0;
        m_a[addr]   = a;
        m_b[addr]   = b;
        m_dly[addr] = dly;
        $display("[TB] write entry %0d = {dly %0d, a %0d, b %0d}", addr, dly, a, b);
    endtask

    // Play a sequence and check it against the timing rules. Entry i first
    // shows valid 2+dly cycles after the start cycle (i=0) or after the
    // previous handshake cycle. Ready stays low for the first `hold`
    // presented cycles. After that it is random at `pct` percent, and it is
    // forced high after 20 more cycles.
    task automatic play(input int len_in, input int pct, input int hold);
        int  n;
        int  ref_c;
        int  cur;
        int  w;
        bit  rdy;
        n = (len_in > DEPTH) ? DEPTH : len_in;
        len   = (AW+1)'(len_in);
        start = 1'b1;
        step();
        start = 1'b0;
        cur   = 1;
        if (n == 0) begin
            chk("len0_done", done, 1);
            chk("len0_valid", out_valid, 0);
            chk("len0_busy", busy, 0);
            step();
            chk("len0_done_clear", done, 0);
            chk("len0_valid_after", out_valid, 0);
            $display("[TB] play len=%0d: no pairs, done pulse checked", len_in);
            return;
        end
        ref_c = 0;
        for (int i = 0; i < n; i++) begin
            while (cur < ref_c + 2 + m_dly[i]) begin
                chk("gap_valid", out_valid, 0);
                chk("gap_busy", busy, 1);
                chk("gap_a_hold", a_out, last_a);
                chk("gap_b_hold", b_out, last_b);
                step();
                cur++;
            end
            w = 0;
            forever begin
                chk("pres_valid", out_valid, 1);
                chk("pres_a", a_out, m_a[i]);
                chk("pres_b", b_out, m_b[i]);
                chk("pres_busy", busy, 1);
                chk("pres_done", done, 0);
                rdy = (w >= hold) && (($urandom_range(99) < pct) || (w >= hold + 20));
                out_ready = rdy;
                step();
                out_ready = 1'b0;
                w++;
                cur++;
                if (rdy) begin
                    ref_c = cur - 1;
                    break;
                end
            end
            last_a = m_a[i];
            last_b = m_b[i];
            $display("[TB] pair %0d (%0d,%0d) accepted in cycle %0d", i, m_a[i], m_b[i], ref_c);
        end
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_valid", out_valid, 0);
        chk("end_a_hold", a_out, last_a);
        step();
        chk("end_done_clear", done, 0);
        chk("end_busy_idle", busy, 0);
        chk("end_b_hold", b_out, last_b);
        $display("[TB] play len=%0d: %0d pairs, done in cycle %0d", len_in, n, ref_c + 1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_dly[i] = 0;
            m_a[i]   = 0;
            m_b[i]   = 0;
        end

        // Reset state
        step();
        step();
        chk("rst_a", a_out, 0);
        chk("rst_b", b_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        step();

        // Back-to-back pairs with ready tied high: cycles 2,4,6,8; done in 9
        twrite(0, 1, 2, 0);
        twrite(1, 0, 2, 0);
        twrite(2, 0, 5, 0);
        twrite(3, 0, 14, 0);
        play(4, 100, 0);

        // Delay 3 and ready held low for 5 cycles: valid from 5, handshake in 10
        twrite(0, 7, 9, 3);
        play(1, 100, 5);

        // len = 0 and clamping of len = 12 to 8 entries
        play(0, 100, 0);
        for (int i = 0; i < DEPTH; i++) twrite(i, i + 1, 15 - i, i % 3);
        play(12, 100, 0);

        // Abort while entry 1 is presented
        for (int i = 0; i < 4; i++) twrite(i, i + 4, i + 8, 0);
        len = 4; start = 1'b1; step(); start = 1'b0;
        step();
        chk("abort_v0", out_valid, 1);
        chk("abort_a0", a_out, m_a[0]);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("abort_gap", out_valid, 0);
        step();
        chk("abort_v1", out_valid, 1);
        chk("abort_a1", a_out, m_a[1]);
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_valid_drop", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_no_done", done, 0);
        chk("abort_a_hold", a_out, m_a[1]);
        chk("abort_b_hold", b_out, m_b[1]);
        step();
        chk("abort_no_done2", done, 0);
        last_a = m_a[1];
        last_b = m_b[1];
        $display("[TB] abort in PRESENT of entry 1 checked");
        play(4, 100, 0);

        // Rewrites during playback: entry 2 changes, the presented entry 1 does not
        for (int i = 0; i < 3; i++) twrite(i, i + 10, i + 1, 0);
        len = 3; start = 1'b1; step(); start = 1'b0;
        step();
        chk("rw_v0", out_valid, 1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        step();
        chk("rw_v1", out_valid, 1);
        chk("rw_a1", a_out, 11);
        twrite(2, 3, 3, 0);
        chk("rw_a1_after_w2", a_out, 11);
        twrite(1, 9, 9, 0);
        chk("rw_a1_after_w1", a_out, 11);
        chk("rw_b1_after_w1", b_out, 2);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("rw_gap", out_valid, 0);
        step();
        chk("rw_v2", out_valid, 1);
        chk("rw_a2", a_out, 3);
        chk("rw_b2", b_out, 3);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("rw_done", done, 1);
        step();
        last_a = 3;
        last_b = 3;
        $display("[TB] rewrite of pending and presented entries checked");

        // Maximum delay without wrap
        twrite(0, 5, 6, 255);
        play(1, 100, 0);

        // Randomised tables, lengths and ready patterns
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++)
                twrite(i, $urandom_range(15), $urandom_range(15), $urandom_range(4));
            play($urandom_range(15), $urandom_range(100, 30), $urandom_range(2));
        end

        // Asynchronous reset mid-WAIT clears outputs and table
        twrite(0, 12, 13, 10);
        twrite(1, 14, 15, 0);
        play(1, 100, 0);
        len = 2; start = 1'b1; step(); start = 1'b0;
        step();
        chk("prerst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a", a_out, 0);
        chk("arst_b", b_out, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            m_dly[i] = 0;
            m_a[i]   = 0;
            m_b[i]   = 0;
        end
        last_a = 0;
        last_b = 0;
        step();
        $display("[TB] async reset mid-WAIT checked");
        play(1, 100, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
